// File: rtl/conv_ifm_streamer_pkg.sv
// rtl/conv_ifm_streamer_pkg.sv - shared state encoding and derived geometry for the IFM streamer
package conv_ifm_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } stream_state_e;

    function automatic int num_passes(input int filters, input int units);
        return filters / units;
    endfunction

    function automatic int words_per_channel(input int size);
        return size * size;
    endfunction

    function automatic int words_per_pass(input int size, input int depth);
        return size * size * depth;
    endfunction

    // Values for the default layer geometry, shared with the layer controller.
    localparam int NUMBER_OF_PASSES  = num_passes(16, 2);
    localparam int WORDS_PER_CHANNEL = words_per_channel(14);
    localparam int WORDS_PER_PASS    = words_per_pass(14, 6);

endpackage

// File: rtl/conv_ifm_streamer_addr_gen.sv
// rtl/conv_ifm_streamer_addr_gen.sv - address, channel-position and pass counters with last flags
module stream_addr_gen #(
    parameter int ADDR_W            = 5,
    parameter int POS_W             = 4,
    parameter int PASS_W            = 2,
    parameter int WORDS_PER_CHANNEL = 16,
    parameter int WORDS_PER_PASS    = 32,
    parameter int NUMBER_OF_PASSES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_in_channel_o,
    output logic              last_in_pass_o,
    output logic              last_pass_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [POS_W-1:0]  pos_q,  pos_d;
    logic [PASS_W-1:0] pass_q, pass_d;

    assign addr_o            = addr_q;
    assign last_in_channel_o = (pos_q == POS_W'(WORDS_PER_CHANNEL - 1));
    assign last_in_pass_o    = (addr_q == ADDR_W'(WORDS_PER_PASS - 1));
    assign last_pass_o       = (pass_q == PASS_W'(NUMBER_OF_PASSES - 1));

    always_comb begin
        addr_d = addr_q;
        pos_d  = pos_q;
        pass_d = pass_q;
        if (clear_i) begin
            addr_d = '0;
            pos_d  = '0;
            pass_d = '0;
        end else if (advance_i) begin
            addr_d = last_in_pass_o    ? '0 : addr_q + 1'b1;
            pos_d  = last_in_channel_o ? '0 : pos_q + 1'b1;
            if (last_in_pass_o) begin
                pass_d = pass_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            pos_q  <= '0;
            pass_q <= '0;
        end else begin
            addr_q <= addr_d;
            pos_q  <= pos_d;
            pass_q <= pass_d;
        end
    end

endmodule

// File: rtl/conv_ifm_streamer.sv
// rtl/conv_ifm_streamer.sv - streams a stored IFM to the conv datapath once per filter pass
module conv_ifm_streamer
    import conv_ifm_streamer_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int IFM_SIZE          = 14,
    parameter int IFM_DEPTH         = 6,
    parameter int NUMBER_OF_FILTERS = 16,
    parameter int NUMBER_OF_UNITS   = 2,
    parameter int ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE * IFM_SIZE * IFM_DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stall,
    input  logic [DATA_WIDTH-1:0]       ifm_data_in,
    output logic                        ifm_enable_read,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address,
    output logic [DATA_WIDTH-1:0]       data_out_for_next,
    output logic                        fifo_enable,
    output logic                        channel_done,
    output logic                        pass_done,
    output logic                        busy,
    output logic                        done
);

    localparam int NP     = num_passes(NUMBER_OF_FILTERS, NUMBER_OF_UNITS);
    localparam int WPC    = words_per_channel(IFM_SIZE);
    localparam int WPP    = words_per_pass(IFM_SIZE, IFM_DEPTH);
    localparam int POS_W  = $clog2(WPC);
    localparam int PASS_W = $clog2(NP + 1);

    stream_state_e state_q;
    logic          valid_q;
    logic          ch_last_q;
    logic          pass_last_q;
    logic          issue;
    logic          last_in_channel;
    logic          last_in_pass;
    logic          last_pass;

    // A read goes out only while streaming and the consumer is not holding us off.
    assign issue = (state_q == READ) && !stall;

    stream_addr_gen #(
        .ADDR_W            (ADDRESS_SIZE_IFM),
        .POS_W             (POS_W),
        .PASS_W            (PASS_W),
        .WORDS_PER_CHANNEL (WPC),
        .WORDS_PER_PASS    (WPP),
        .NUMBER_OF_PASSES  (NP)
    ) u_addr_gen (
        .clk               (clk),
        .reset             (reset),
        .clear_i           (state_q == IDLE),
        .advance_i         (issue),
        .addr_o            (ifm_address),
        .last_in_channel_o (last_in_channel),
        .last_in_pass_o    (last_in_pass),
        .last_pass_o       (last_pass)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            ch_last_q   <= 1'b0;
            pass_last_q <= 1'b0;
        end else begin
            // Last flags travel with the read so they line up with its returned word.
            valid_q     <= issue;
            ch_last_q   <= issue && last_in_channel;
            pass_last_q <= issue && last_in_pass;
            case (state_q)
                IDLE:    if (start) state_q <= READ;
                READ:    if (issue && last_in_pass && last_pass) state_q <= DRAIN;
                DRAIN:   state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ifm_enable_read   = issue;
    assign fifo_enable       = valid_q;
    assign data_out_for_next = valid_q ? ifm_data_in : '0;
    assign channel_done      = ch_last_q;
    assign pass_done         = pass_last_q;
    assign busy              = (state_q == READ) || (state_q == DRAIN);
    assign done              = (state_q == DONE);

endmodule

// File: tb/tb_conv_ifm_streamer.sv
// tb/tb_conv_ifm_streamer.sv - directed self-checking bench for conv_ifm_streamer
module tb_conv_ifm_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] ifm_data_in = '0;
    logic        ifm_enable_read;
    logic [4:0]  ifm_address;
    logic [31:0] data_out_for_next;
    logic        fifo_enable, channel_done, pass_done, busy, done;

    logic        reset2 = 1'b1;
    logic        start2 = 1'b0;
    logic [31:0] ifm_data_in2 = '0;
    logic        ifm_enable_read2;
    logic [10:0] ifm_address2;
    logic [31:0] data_out2;
    logic        fe2, cd2, pd2, busy2, done2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    bit log_en  = 1'b0;
    int fe_cyc[$];
    int fe_dat[$];
    int cd_cyc[$];
    int pd_cyc[$];
    int dn_cyc[$];
    int bad_zero = 0;
    bit busy_log[0:127];

    bit log2_en = 1'b0;
    int t0_2 = 0;
    int n_fe2 = 0, n_cd2 = 0, n_pd2 = 0, n_dn2 = 0, dn2_cyc = -1, bad2 = 0;

    always #5 clk = ~clk;

    conv_ifm_streamer #(
        .DATA_WIDTH (32), .IFM_SIZE (4), .IFM_DEPTH (2),
        .NUMBER_OF_FILTERS (4), .NUMBER_OF_UNITS (2)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .stall (stall),
        .ifm_data_in (ifm_data_in), .ifm_enable_read (ifm_enable_read),
        .ifm_address (ifm_address), .data_out_for_next (data_out_for_next),
        .fifo_enable (fifo_enable), .channel_done (channel_done),
        .pass_done (pass_done), .busy (busy), .done (done)
    );

    conv_ifm_streamer dut_def (
        .clk (clk), .reset (reset2), .start (start2), .stall (1'b0),
        .ifm_data_in (ifm_data_in2), .ifm_enable_read (ifm_enable_read2),
        .ifm_address (ifm_address2), .data_out_for_next (data_out2),
        .fifo_enable (fe2), .channel_done (cd2),
        .pass_done (pd2), .busy (busy2), .done (done2)
    );

    // Buffer models: stored word equals its address, one cycle of read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifm_enable_read)  ifm_data_in  <= 32'(ifm_address);
        if (ifm_enable_read2) ifm_data_in2 <= 32'(ifm_address2);
    end

    always @(negedge clk) begin
        if (log_en) begin
            if (fifo_enable) begin
                fe_cyc.push_back(cyc - t0);
                fe_dat.push_back(int'(data_out_for_next));
            end else if (data_out_for_next != '0) begin
                bad_zero++;
            end
            if (channel_done) cd_cyc.push_back(cyc - t0);
            if (pass_done)    pd_cyc.push_back(cyc - t0);
            if (done)         dn_cyc.push_back(cyc - t0);
            if (cyc - t0 >= 0 && cyc - t0 < 128) busy_log[cyc - t0] = busy;
        end
        if (log2_en) begin
            if (fe2) begin
                if (int'(data_out2) != n_fe2 % 1176) bad2++;
                n_fe2++;
            end
            if (cd2) n_cd2++;
            if (pd2) n_pd2++;
            if (done2) begin
                n_dn2++;
                if (dn2_cyc < 0) dn2_cyc = cyc - t0_2;
            end
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cyc(input int i, input int sa, input int sh);
        return i + 2 + ((i >= sa) ? sh : 0);
    endfunction

    task automatic clear_log();
        fe_cyc.delete(); fe_dat.delete(); cd_cyc.delete();
        pd_cyc.delete(); dn_cyc.delete();
        bad_zero = 0;
        for (int i = 0; i < 128; i++) busy_log[i] = 1'b0;
    endtask

    task automatic run_stream(input int stall_from, input int stall_to,
                              input int extra_start, input int len);
        clear_log();
        start = 1'b1; t0 = cyc; log_en = 1'b1;
        step();
        start = 1'b0;
        while (cyc - t0 < len) begin
            stall = (cyc - t0 >= stall_from) && (cyc - t0 < stall_to);
            start = (cyc - t0 == extra_start);
            step();
        end
        stall = 1'b0; start = 1'b0; log_en = 1'b0;
    endtask

    // Words are indexed 0..63 over both passes; words from index sa onward slip by sh cycles.
    task automatic check_stream(input string tag, input int sa, input int sh);
        check_val({tag, "_fe_count"}, fe_cyc.size(), 64);
        for (int i = 0; i < 64 && i < fe_cyc.size(); i++) begin
            check_val({tag, "_fe_cyc"}, fe_cyc[i], exp_cyc(i, sa, sh));
            check_val({tag, "_fe_data"}, fe_dat[i], i % 32);
        end
        check_val({tag, "_cd_count"}, cd_cyc.size(), 4);
        for (int k = 0; k < 4 && k < cd_cyc.size(); k++)
            check_val({tag, "_cd_cyc"}, cd_cyc[k], exp_cyc(16 * k + 15, sa, sh));
        check_val({tag, "_pd_count"}, pd_cyc.size(), 2);
        for (int k = 0; k < 2 && k < pd_cyc.size(); k++)
            check_val({tag, "_pd_cyc"}, pd_cyc[k], exp_cyc(32 * k + 31, sa, sh));
        check_val({tag, "_done_count"}, dn_cyc.size(), 1);
        if (dn_cyc.size() > 0) check_val({tag, "_done_cyc"}, dn_cyc[0], exp_cyc(63, sa, sh) + 1);
        check_val({tag, "_data_zero"}, bad_zero, 0);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_rd"},   int'(ifm_enable_read), 0);
        check_val({tag, "_addr"}, int'(ifm_address), 0);
        check_val({tag, "_fe"},   int'(fifo_enable), 0);
        check_val({tag, "_data"}, int'(data_out_for_next), 0);
        check_val({tag, "_cd"},   int'(channel_done), 0);
        check_val({tag, "_pd"},   int'(pass_done), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        step(); step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check_quiet("reset");
        step();

        run_stream(-1, -1, -1, 75);
        check_stream("plain", 64, 0);
        check_val("plain_busy1",  int'(busy_log[1]), 1);
        check_val("plain_busy65", int'(busy_log[65]), 1);
        check_val("plain_busy66", int'(busy_log[66]), 0);

        run_stream(5, 10, -1, 80);
        check_stream("stall", 4, 5);

        run_stream(-1, -1, 20, 75);
        check_stream("restart", 64, 0);

        start = 1'b1; t0 = cyc;
        step();
        start = 1'b0;
        while (cyc - t0 < 15) begin
            if (cyc - t0 == 10) begin
                reset = 1'b1;
            end else if (cyc - t0 == 11) begin
                reset = 1'b0;
                @(negedge clk);
                check_quiet("midreset");
            end
            step();
        end
        run_stream(-1, -1, -1, 75);
        check_stream("after_reset", 64, 0);

        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_start_busy", int'(busy), 0);
            check_val("rst_start_rd", int'(ifm_enable_read), 0);
            step();
        end

        reset2 = 1'b0;
        step();
        start2 = 1'b1; t0_2 = cyc; log2_en = 1'b1;
        step();
        start2 = 1'b0;
        while (cyc - t0_2 < 9420) step();
        log2_en = 1'b0;
        check_val("def_fe_count", n_fe2, 9408);
        check_val("def_cd_count", n_cd2, 48);
        check_val("def_pd_count", n_pd2, 8);
        check_val("def_done_count", n_dn2, 1);
        check_val("def_done_cyc", dn2_cyc, 9410);
        check_val("def_data", bad2, 0);
        check_val("def_busy_end", int'(busy2), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_ifm_streamer.md
Name: conv_ifm_streamer

Overview:
Transmit side of the conv datapath pixel stream. Reads a stored IFM (IFM_SIZE x IFM_SIZE x IFM_DEPTH) from a single-port buffer with 1-cycle read latency. Drives data_in_A_from_previous / fifo_enable of a convB datapath in channel-major, row-major raster order. Re-streams the whole IFM once per filter pass, NUMBER_OF_FILTERS/NUMBER_OF_UNITS passes in total. Sits between the previous layer's output buffer and the conv datapath. Start/done handshake to the layer controller.

Parameters:
DATA_WIDTH, 32, pixel word width
IFM_SIZE, 14, IFM row/column length
IFM_DEPTH, 6, number of IFM channels
NUMBER_OF_FILTERS, 16, filters in the layer
NUMBER_OF_UNITS, 2, parallel conv units; NUMBER_OF_PASSES = NUMBER_OF_FILTERS/NUMBER_OF_UNITS (must divide exactly)
ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE*IFM_DEPTH), buffer address width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to begin streaming; ignored unless idle
stall  in  1  downstream hold; while high no new read is issued
ifm_data_in  in  DATA_WIDTH  buffer read data, valid 1 cycle after a read
ifm_enable_read  out  1  buffer read strobe
ifm_address  out  ADDRESS_SIZE_IFM  buffer read address
data_out_for_next  out  DATA_WIDTH  pixel to conv datapath
fifo_enable  out  1  pixel-valid / shift strobe to conv datapath
channel_done  out  1  pulse with the last pixel of each channel
pass_done  out  1  pulse with the last pixel of each pass
busy  out  1  high from first read until final pixel delivered
done  out  1  one-cycle pulse after the final pixel of the final pass

Behaviour:
- Reset (sync, high): state IDLE. Counters cleared. All outputs 0 on the next edge. Any in-flight read is discarded: no fifo_enable for it.
- N = IFM_SIZE*IFM_SIZE*IFM_DEPTH words per pass. ifm_address is a linear counter 0..N-1, equal to c*IFM_SIZE^2 + row*IFM_SIZE + col.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 -> READ. Address counter and pass counter cleared.
- READ: if stall=0, assert ifm_enable_read with the current ifm_address, then increment the address.
  - If stall=1, ifm_enable_read=0 and the address holds.
  - After address N-1 is issued: address wraps to 0 and the pass counter increments.
  - If the pass counter was NUMBER_OF_PASSES-1, go to DRAIN instead.
- DRAIN: wait one cycle for the final word -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- fifo_enable = ifm_enable_read delayed one cycle.
- data_out_for_next = ifm_data_in, combinational pass-through; it is 0 whenever fifo_enable=0.
- stall is a "do not issue" request. One word already in flight is still delivered the cycle after stall rises; the consumer tolerates exactly one word.
- channel_done: asserted with the fifo_enable cycle whose word address mod IFM_SIZE^2 = IFM_SIZE^2-1. Track this with a registered address-tag or last flag.
- pass_done: asserted with the fifo_enable cycle of word N-1. The final pass_done coincides with the last channel_done.
- busy: 1 in READ and DRAIN, 0 in IDLE and DONE.
- Latency, no stall: start sampled at cycle 0.
  - Reads at cycles 1..P*N.
  - fifo_enable at cycles 2..P*N+1.
  - done at cycle P*N+2.
- start while busy or in DONE: ignored, no restart.
- start and reset in the same cycle: reset wins.
- Stall held indefinitely: state, address and pass counters all hold. After the in-flight word, fifo_enable stays 0.
- Counter widths:
  - address ADDRESS_SIZE_IFM bits.
  - pass counter $clog2(NUMBER_OF_PASSES+1) bits.
  - channel position counter $clog2(IFM_SIZE*IFM_SIZE) bits.
  - No arithmetic on data.

Decomposition:
- Shared package: state encoding (IDLE/READ/DRAIN/DONE) and the derived constants NUMBER_OF_PASSES, WORDS_PER_CHANNEL, WORDS_PER_PASS. These are reused by the layer controller.
- One natural sub-module: stream_addr_gen. It holds the address, channel-position and pass counters with wrap and last-flags, driven by an advance input.
- FSM, the 1-cycle valid/last pipeline and the output muxing stay in the top.

Test Plan:
- Params IFM_SIZE=4, IFM_DEPTH=2, FILTERS=4, UNITS=2 (P=2, N=32); buffer holds value=address; start at cycle 0. Required:
  - fifo_enable high cycles 2..65, data 0..31, 0..31.
  - channel_done at cycles 17, 33, 49, 65.
  - pass_done at cycles 33, 65.
  - done at cycle 66; busy low at 66.
- Stall high cycles 5..9 in the above run. Required:
  - Reads stop at address 3; the word for address 3 is still delivered at cycle 5.
  - No fifo_enable at cycles 6..10.
  - Stream resumes with address 4 delivered at cycle 11; done shifts by 5 to cycle 71.
- Start pulse at cycle 20 while busy: no change to the address sequence; exactly 64 fifo_enable pulses and one done.
- Reset asserted at cycle 10 mid-stream. Required:
  - All outputs 0 at cycle 11, with no fifo_enable for the in-flight word.
  - A new start at cycle 15 gives a full 0..31 sequence from address 0.
- Start and reset in the same cycle: remains IDLE, busy=0, no ifm_enable_read.
- Default params (N=1176, P=8): 9408 fifo_enable pulses, 48 channel_done, 8 pass_done, done at cycle 9410.
